// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Moore control FSM for a shared-memory multicycle RISC-V
//               datapath. Decodes the opcode held in the instruction register
//               and steps lw/sw/R/I/beq/jal through fetch, decode, execute,
//               memory and writeback, stalling on mem_ready.
// Ports       : clk, reset_n (async active-low)
//               opcode[6:0]  - instr[6:0] from the instruction register
//               zero         - ALU zero flag (branch decision)
//               mem_ready    - memory completed current access this cycle
//               pc_write, adr_src, mem_write, ir_write, reg_write - enables
//               result_src, alu_src_a, alu_src_b, alu_op, imm_src - selects
//               illegal      - one-cycle pulse on unrecognised opcode
//               state_dbg    - current state encoding (STATE_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int ILLEGAL_HALT = 0,
    parameter int STATE_W      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         imm_src,
    output logic               reg_write,
    output logic               illegal,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd15
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        w_pc_write;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_reg_write;
    logic        w_illegal;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and Moore outputs (a few strobes also look at mem_ready/zero)
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = S_FETCH;
        w_pc_write   = 1'b0;
        adr_src      = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC <= PC + 4 through the shared ALU, same cycle IR loads
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                w_next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes oldPC + imm for a possible branch/jump
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    c_OP_LOAD, c_OP_STORE: w_next_state = S_MEMADR;
                    c_OP_RTYPE:            w_next_state = S_EXECUTER;
                    c_OP_ITYPE:            w_next_state = S_EXECUTEI;
                    c_OP_BEQ:              w_next_state = S_BEQ;
                    c_OP_JAL:              w_next_state = S_JAL;
                    default: begin
                        w_illegal    = 1'b1;
                        w_next_state = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (opcode == c_OP_LOAD) begin
                    w_next_state = S_MEMREAD;
                end else if (opcode == c_OP_STORE) begin
                    w_next_state = S_MEMWRITE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEMREAD: begin
                adr_src      = 1'b1;
                w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe stays up through the accepting cycle, drops after
                adr_src      = 1'b1;
                w_mem_write  = 1'b1;
                w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                alu_src_a    = 2'b10;
                alu_op       = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                alu_op       = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_BEQ: begin
                // ALU out register holds the target computed in DECODE
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                w_pc_write = zero;
            end
            S_JAL: begin
                // PC <= target from DECODE while ALU forms oldPC + 4 for rd
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                w_pc_write   = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Immediate format follows the IR opcode in every state
    always_comb begin
        case (opcode)
            c_OP_STORE: imm_src = 2'b01;
            c_OP_BEQ:   imm_src = 2'b10;
            c_OP_JAL:   imm_src = 2'b11;
            default:    imm_src = 2'b00;
        endcase
    end

    // Strobes are qualified with reset_n so nothing fires while reset is held,
    // even though FETCH strobes would otherwise follow mem_ready.
    assign pc_write  = w_pc_write  & reset_n;
    assign ir_write  = w_ir_write  & reset_n;
    assign mem_write = w_mem_write & reset_n;
    assign reg_write = w_reg_write & reset_n;
    assign illegal   = w_illegal   & reset_n;

    assign state_dbg = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the shared multicycle RISC-V datapath: one memory for instructions and data, one ALU reused for PC+4, branch target and address generation, and an instruction register.
- Replaces the single-cycle main decoder when the core is built in multicycle form.
- Decodes the opcode held in the instruction register and steps each instruction through fetch, decode, execute, memory and writeback.
- Handles memory wait-states through a `mem_ready` handshake.

Parameters:
- `ILLEGAL_HALT`, default 0: 0 = illegal opcode pulses `illegal` and returns to FETCH. 1 = enter HALT and stay there until reset.
- `STATE_W`, default 4: width of the `state_dbg` output; must be >= 4.

Ports:
- `clk` input 1: system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `opcode` input 7: instr[6:0] taken from the instruction register.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory has completed the current access this cycle.
- `pc_write` output 1: PC register enable.
- `adr_src` output 1: memory address select. 0 = PC, 1 = ALU result register.
- `mem_write` output 1: memory write strobe.
- `ir_write` output 1: instruction register (and old-PC register) enable.
- `result_src` output 2: 00 = ALU out register, 01 = data register, 10 = ALU result.
- `alu_src_a` output 2: 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b` output 2: 00 = rs2, 01 = imm, 10 = constant 4.
- `alu_op` output 2: 00 = add, 01 = sub (compare), 10 = funct-decoded.
- `imm_src` output 2: 00 = I, 01 = S, 10 = B, 11 = J.
- `reg_write` output 1: register file write enable.
- `illegal` output 1: one-cycle pulse on an unrecognised opcode.
- `state_dbg` output STATE_W: current state encoding.

Behaviour:
- Reset: asynchronous on `reset_n` low.
  - state = FETCH.
  - `pc_write`, `ir_write`, `mem_write`, `reg_write` and `illegal` are forced to 0 while `reset_n` is low, regardless of `mem_ready`.
  - Mux selects take their FETCH values.
  - A reset mid-instruction abandons it; no partial write strobe is issued.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, HALT=15.
- Any unspecified output in a state is 0.
- FETCH:
  - Outputs: `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `ir_write` = `mem_ready`; `pc_write` = `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE. The PC advances exactly once per fetch.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (branch/jump target). Next state by `opcode`:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR.
  - 0110011 -> EXECUTER.
  - 0010011 -> EXECUTEI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - Any other opcode: `illegal`=1 for this cycle, then FETCH, or HALT if `ILLEGAL_HALT`=1.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Goes to MEMREAD if lw, MEMWRITE if sw.
- MEMREAD: `adr_src`=1, `result_src`=00. Holds until `mem_ready`, then MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Next state FETCH.
- MEMWRITE:
  - `adr_src`=1, `result_src`=00, `mem_write`=1 held continuously until `mem_ready`.
  - Next state FETCH in the cycle after `mem_ready`; `mem_write` is 0 from then on.
- EXECUTER: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Next state ALUWB.
- EXECUTEI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Next state ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1. Next state FETCH.
- BEQ:
  - `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00.
  - `pc_write` = `zero` (combinational).
  - Next state FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1. Next state ALUWB (writes rd = PC+4).
- HALT: all strobes 0; stays in HALT until reset.
- `imm_src`: combinational from `opcode` in every state.
  - lw / 0010011 -> 00; sw -> 01; beq -> 10; jal -> 11.
  - Any other opcode -> 00.
- Instruction latencies with `mem_ready` always 1, counted FETCH to return to FETCH:
  - lw 5 cycles; sw 4; R-type and I-type 4; beq 3; jal 4.
  - Each memory wait cycle adds 1.
- `opcode` is only sampled in DECODE and MEMADR; the instruction register is stable there because `ir_write` is only asserted in FETCH.
- Unreachable state encodings go to FETCH on the next edge with all strobes 0.

Test Plan:
- Reset: assert `reset_n`=0 mid-MEMWRITE with `mem_ready`=1.
  - Required: `mem_write`=0 immediately (asynchronous), `state_dbg`=0.
  - After release with `mem_ready`=1: `ir_write`=`pc_write`=1 in the first cycle.
- lw, `opcode`=0000011, `mem_ready`=1:
  - Required state sequence: 0,1,2,3,4,0.
  - `reg_write`=1 and `result_src`=01 only in state 4; `imm_src`=00 throughout.
- sw with `mem_ready` low for 2 cycles in MEMWRITE:
  - Required: `mem_write` high for exactly 3 cycles, `adr_src`=1 throughout.
  - `reg_write` never asserted; `imm_src`=01.
- beq run twice:
  - With `zero`=1: `pc_write`=1 in BEQ.
  - With `zero`=0: `pc_write`=0.
  - Both cases: `alu_op`=01, 3-cycle instruction.
- R-type 0110011 then jal 1101111:
  - R-type sequence: 0,1,6,8,0 with `alu_src_b`=00 in state 6.
  - jal sequence: 0,1,10,8,0 with `pc_write`=1 in state 10, `imm_src`=11.
- Illegal opcode 1111111:
  - `ILLEGAL_HALT`=0: `illegal` pulses 1 cycle in DECODE, next state 0.
  - `ILLEGAL_HALT`=1: state 15 held for 20 cycles with all strobes 0, until reset.
